// File: rtl/sparse_stream_pkg.sv
// Shared types and constants for the 17-bit sparse tile token stream.
package sparse_stream_pkg;

  localparam int TOKEN_W = 17;

  typedef logic [TOKEN_W-1:0] token_t;

  localparam token_t DONE_TOKEN = 17'h10100;

  // Right-shift Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_RECV,
    ST_DONE
  } sink_state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/stream_stall_lfsr.sv
// 16-bit Galois LFSR that paces sink backpressure; load wins over advance.
module stream_stall_lfsr
  import sparse_stream_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = SEED;
    end else if (advance) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/tile_read_sink.sv
// Receive end of the sparse tile token stream: captures tokens, counts DONE tokens,
// raises done after TX_NUM of them, optionally throttles ready from an LFSR.
module tile_read_sink
  import sparse_stream_pkg::*;
#(
  parameter int          DEPTH       = 2048,
  parameter int          TX_NUM      = 1,
  parameter int          STALL_EN    = 0,
  parameter int          STALL_SHIFT = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [TOKEN_W-1:0]       data,
  input  logic                     valid,
  output logic                     ready,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [TOKEN_W-1:0]       rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(TX_NUM + 1);

  if (TX_NUM < 1) begin : g_bad_tx_num
    $error("tile_read_sink: TX_NUM must be at least 1");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("tile_read_sink: LFSR_SEED must be nonzero");
  end
  if ((1 << AW) != DEPTH) begin : g_bad_depth
    $error("tile_read_sink: DEPTH must be a power of two");
  end

  sink_state_e   state_q, state_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          overflow_q, overflow_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] done_cnt_q, done_cnt_d;
  logic [1:0]    stall_cnt_q, stall_cnt_d;

  logic          hs;
  logic          mem_we;
  logic          lfsr_load;
  logic          lfsr_adv;
  logic [15:0]   lfsr_val;
  logic [1:0]    stall_fld;

  token_t        mem [DEPTH];
  token_t        rd_data_q;

  stream_stall_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .value   (lfsr_val)
  );

  assign stall_fld = 2'(lfsr_val >> STALL_SHIFT);
  assign hs        = valid && ready_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    done_cnt_d  = done_cnt_q;
    done_d      = done_q;
    overflow_d  = overflow_q;
    stall_cnt_d = stall_cnt_q;
    mem_we      = 1'b0;
    lfsr_load   = 1'b0;
    lfsr_adv    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        count_d     = '0;
        done_cnt_d  = '0;
        done_d      = 1'b0;
        overflow_d  = 1'b0;
        stall_cnt_d = 2'd0;
        lfsr_load   = 1'b1;
        if (!flush) state_d = ST_RECV;
      end
      ST_RECV: begin
        // A flush discards any token handshaken in the same cycle.
        if (flush) begin
          state_d = ST_FLUSH;
        end else begin
          lfsr_adv = 1'b1;
          if (stall_cnt_q != 2'd0) stall_cnt_d = stall_cnt_q - 2'd1;
          if (hs) begin
            if (STALL_EN != 0) stall_cnt_d = stall_fld;
            if (count_q[AW]) begin
              overflow_d = 1'b1;
            end else begin
              mem_we  = 1'b1;
              count_d = count_q + CW'(1);
            end
            if (data == DONE_TOKEN) begin
              done_cnt_d = done_cnt_q + DW'(1);
              if (done_cnt_d == DW'(TX_NUM)) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
            end
          end
        end
      end
      ST_DONE: begin
        if (flush) state_d = ST_FLUSH;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_RECV) && (stall_cnt_d == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      count_q     <= '0;
      done_cnt_q  <= '0;
      stall_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
      done_cnt_q  <= done_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Read-before-write: a same-address read in the write cycle returns old data.
  always_ff @(posedge clk) begin
    if (mem_we) mem[count_q[AW-1:0]] <= data;
    rd_data_q <= mem[rd_addr];
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign count    = count_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_tile_read_sink.sv
// Self-checking bench: four sink configurations driven with random tokens and checked
// against a queue/arithmetic reference of accepted tokens and expected ready gaps.
module tb_tile_read_sink;
  import sparse_stream_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          SH   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush_v    [4];
  token_t      data_v     [4];
  logic        valid_v    [4];
  logic [10:0] rd_addr_v  [4];
  logic        ready_v    [4];
  logic        done_v     [4];
  logic        overflow_v [4];
  logic [11:0] count_v    [4];
  token_t      rd_data_v  [4];

  int n_cmp  = 0;
  int n_fail = 0;

  int depth_of [4] = '{2048, 2048, 4, 2048};
  bit stall_of [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  token_t sent [$];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int D  = (g == 2) ? 4 : 2048;
    localparam int T  = (g == 1) ? 2 : 1;
    localparam int S  = (g == 3) ? 1 : 0;
    localparam int AW = $clog2(D);
    logic [AW:0]   cnt;
    logic [AW-1:0] ra;
    assign ra = AW'(rd_addr_v[g]);
    tile_read_sink #(
      .DEPTH       (D),
      .TX_NUM      (T),
      .STALL_EN    (S),
      .STALL_SHIFT (SH),
      .LFSR_SEED   (SEED)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush_v[g]),
      .data     (data_v[g]),
      .valid    (valid_v[g]),
      .ready    (ready_v[g]),
      .done     (done_v[g]),
      .count    (cnt),
      .overflow (overflow_v[g]),
      .rd_addr  (ra),
      .rd_data  (rd_data_v[g])
    );
    assign count_v[g] = 12'(cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic token_t rand_tok();
    token_t t;
    t = token_t'($urandom);
    if (t == DONE_TOKEN) t = t ^ 17'h1;
    return t;
  endfunction

  task automatic do_flush(input int i);
    flush_v[i] = 1'b1;
    tick();
    flush_v[i] = 1'b0;
    tick();
  endtask

  // Presents every token in 'sent' back to back, starting in the first RECV cycle.
  // Expected ready: after a handshake at cycle t, ready returns at t+1+stall,
  // stall being 2 bits of the LFSR value of cycle t (LFSR = SEED at t=0).
  task automatic stream(input int i);
    int          t      = 0;
    int          nxt    = 0;
    int          waited = 0;
    logic [15:0] l      = SEED;
    bit          hung   = 1'b0;
    foreach (sent[k]) begin
      if (hung) break;
      check("done_early", 32'(done_v[i]), 32'd0);
      data_v[i]  = sent[k];
      valid_v[i] = 1'b1;
      waited     = 0;
      while (1) begin
        check("ready", 32'(ready_v[i]), 32'(t >= nxt));
        if (ready_v[i] === 1'b1) begin
          nxt = t + 1 + (stall_of[i] ? int'((l >> SH) & 16'h3) : 0);
          tick();
          t++;
          l = ref_step(l);
          break;
        end
        tick();
        t++;
        l = ref_step(l);
        waited++;
        if (waited > 8) begin
          check("ready_timeout", 32'(waited), 32'd8);
          hung = 1'b1;
          break;
        end
      end
    end
    valid_v[i] = 1'b0;
  endtask

  task automatic readback(input int i, input string tag);
    int n;
    n = (sent.size() < depth_of[i]) ? sent.size() : depth_of[i];
    for (int a = 0; a < n; a++) begin
      rd_addr_v[i] = 11'(a);
      tick();
      check(tag, 32'(rd_data_v[i]), 32'(sent[a]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      flush_v[i]   = 1'b0;
      data_v[i]    = '0;
      valid_v[i]   = 1'b0;
      rd_addr_v[i] = '0;
    end
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check("rst_ready", 32'(ready_v[i]), 32'd0);
      check("rst_done", 32'(done_v[i]), 32'd0);
      check("rst_count", 32'(count_v[i]), 32'd0);
      check("rst_overflow", 32'(overflow_v[i]), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // Basic transfer, TX_NUM=1.
    sent.delete();
    for (int k = 0; k < 4; k++) sent.push_back(rand_tok());
    sent.push_back(DONE_TOKEN);
    do_flush(0);
    stream(0);
    check("t1_done", 32'(done_v[0]), 32'd1);
    check("t1_count", 32'(count_v[0]), 32'd5);
    check("t1_overflow", 32'(overflow_v[0]), 32'd0);
    check("t1_ready_in_done", 32'(ready_v[0]), 32'd0);
    readback(0, "t1_mem");

    // Two DONE tokens required.
    sent.delete();
    sent.push_back(rand_tok());
    sent.push_back(DONE_TOKEN);
    sent.push_back(rand_tok());
    sent.push_back(DONE_TOKEN);
    do_flush(1);
    stream(1);
    check("t2_done", 32'(done_v[1]), 32'd1);
    check("t2_count", 32'(count_v[1]), 32'd4);

    // Overflow on a 4-deep memory, final DONE arrives while full.
    sent.delete();
    for (int k = 0; k < 5; k++) sent.push_back(rand_tok());
    sent.push_back(DONE_TOKEN);
    do_flush(2);
    stream(2);
    check("t3_count", 32'(count_v[2]), 32'd4);
    check("t3_overflow", 32'(overflow_v[2]), 32'd1);
    check("t3_done", 32'(done_v[2]), 32'd1);
    readback(2, "t3_mem");

    // LFSR backpressure.
    sent.delete();
    for (int k = 0; k < 100; k++) sent.push_back(rand_tok());
    sent.push_back(DONE_TOKEN);
    do_flush(3);
    stream(3);
    check("t4_count", 32'(count_v[3]), 32'd101);
    check("t4_done", 32'(done_v[3]), 32'd1);
    check("t4_overflow", 32'(overflow_v[3]), 32'd0);
    readback(3, "t4_mem");

    // Flush mid-stream; the token handshaken alongside flush is discarded.
    sent.delete();
    for (int k = 0; k < 3; k++) sent.push_back(rand_tok());
    do_flush(0);
    stream(0);
    check("t5_count_mid", 32'(count_v[0]), 32'd3);
    data_v[0]  = rand_tok();
    valid_v[0] = 1'b1;
    flush_v[0] = 1'b1;
    tick();
    check("t5_flush_prio", 32'(count_v[0]), 32'd3);
    valid_v[0] = 1'b0;
    flush_v[0] = 1'b0;
    tick();
    check("t5_count_clr", 32'(count_v[0]), 32'd0);
    check("t5_done_clr", 32'(done_v[0]), 32'd0);
    sent.delete();
    sent.push_back(rand_tok());
    sent.push_back(rand_tok());
    sent.push_back(DONE_TOKEN);
    stream(0);
    check("t5_count", 32'(count_v[0]), 32'd3);
    check("t5_done", 32'(done_v[0]), 32'd1);
    check("t5_overflow", 32'(overflow_v[0]), 32'd0);
    readback(0, "t5_mem");

    // Reset during RECV.
    sent.delete();
    sent.push_back(rand_tok());
    sent.push_back(rand_tok());
    do_flush(0);
    stream(0);
    check("t6_count_pre", 32'(count_v[0]), 32'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_ready", 32'(ready_v[0]), 32'd0);
    check("t6_done", 32'(done_v[0]), 32'd0);
    check("t6_count", 32'(count_v[0]), 32'd0);
    valid_v[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data_v[0] = rand_tok();
      tick();
    end
    valid_v[0] = 1'b0;
    check("t6_ignored_count", 32'(count_v[0]), 32'd0);
    check("t6_ignored_ready", 32'(ready_v[0]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_read_sink.md
Name: tile_read_sink

Overview:
- Synthesizable receive end of the 17-bit valid/ready token stream used by sparse tile drivers.
- Accepts tokens into a local capture memory and counts handshakes and DONE tokens (17'h10100).
- Asserts `done` once TX_NUM DONE tokens have arrived.
- Optional LFSR-driven backpressure exercises the sender's stall handling; a read port lets the bench or a host dump captured data.

Parameters:
- DEPTH, 2048, capture memory depth in tokens (power of 2).
- TX_NUM, 1, number of DONE tokens that end a transfer.
- STALL_EN, 0, 1 enables pseudo-random deassertion of ready.
- STALL_SHIFT, 0, bit offset of the 2-bit stall field taken from the LFSR.
- LFSR_SEED, 16'hACE1, reset/flush value of the stall LFSR (must be nonzero).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  level flush; pulse high then low to arm a transfer.
- data  in  17  incoming token.
- valid  in  1  sender has a token on data.
- ready  out  1  sink accepts this cycle; registered-state only, no path from valid/data.
- done  out  1  transfer complete, sticky until flush or reset.
- count  out  $clog2(DEPTH)+1  tokens accepted since the last flush, saturates at DEPTH.
- overflow  out  1  sticky; a token was accepted while the memory was full.
- rd_addr  in  $clog2(DEPTH)  capture memory read address.
- rd_data  out  17  mem[rd_addr], 1-cycle read latency.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; ready=0, done=0, count=0, overflow=0, done_cnt=0, stall_cnt=0, lfsr=LFSR_SEED.
  - Memory contents are not reset; rd_data is undefined until first read.
- States: IDLE, FLUSH, RECV, DONE.
  - IDLE: ready=0. flush=1 -> FLUSH.
  - FLUSH: ready=0; clears count, done_cnt, done, overflow, stall_cnt; lfsr=LFSR_SEED. flush=0 -> RECV.
  - RECV: ready = (stall_cnt==0). A handshake is valid&&ready at a clk edge:
    - if count<DEPTH: mem[count[addr]]<=data and count++;
    - else overflow<=1, data dropped, count held at DEPTH.
    - if data==17'h10100: done_cnt++. If done_cnt+1==TX_NUM, go to DONE and set done next cycle.
  - DONE: ready=0, done=1. flush=1 -> FLUSH.
- flush=1 in any state except IDLE forces FLUSH next cycle, aborting an in-progress receive; flush has priority over a same-cycle handshake (that token is discarded).
- Stall (STALL_EN=1):
  - LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances every RECV cycle.
  - On each handshake, stall_cnt <= (lfsr>>STALL_SHIFT)&3.
  - While stall_cnt>0, ready=0 and stall_cnt decrements each cycle.
  - STALL_EN=0: stall_cnt is always 0.
- DONE-token handshakes are written to memory like any other token.
- Simultaneous final DONE token and full memory: overflow=1 and done=1 both set.
- TX_NUM=0 is illegal (elaboration-time assertion).
- Read port is independent of state and may be read during RECV; a same-cycle write and read of the same address returns old data.

Decomposition:
- Package sparse_stream_pkg: TOKEN_W=17, DONE_TOKEN=17'h10100, token_t typedef, sink_state_e enum, LFSR taps constant.
- Sub-module stream_stall_lfsr (seed/advance/load, outputs 16-bit value) is natural.
- Capture memory is inferred inline as a simple dual-port RAM.

Test Plan:
- Reset, flush pulse, 5 tokens {1,2,3,4,17'h10100} with valid held high, STALL_EN=0, TX_NUM=1 -> ready=1 each cycle, count=5, done=1 one cycle after the last handshake, rd_addr 0..4 return the tokens.
- TX_NUM=2, stream {7,17'h10100,8,17'h10100} -> done stays 0 after the first DONE token and rises after the second; count=4.
- DEPTH=4, stream 6 tokens ending in 17'h10100 -> count=4, overflow=1, done=1, mem holds the first 4 tokens.
- STALL_EN=1, STALL_SHIFT=0, 100 tokens plus DONE token -> no token lost or duplicated, ready gaps match a reference LFSR model, count=101.
- flush asserted mid-stream after 3 tokens, then 2 tokens plus DONE token -> count=3 at end (cleared), done=1, overflow=0.
- rst_n=0 for one cycle during RECV -> next cycle state=IDLE, ready=0, done=0, count=0; tokens are ignored until the next flush.
